// File: rtl/byte_pack_fifo.sv
// Packs a little-endian byte stream into 16-bit words and buffers them in a FIFO with a registered output stage.
// Word is written on the edge accepting its completing byte and appears one edge later; din_rdy drops once usedw reaches AFULL_THR.
module byte_pack_fifo #(
  parameter int          DEPTH     = 64,
  parameter int          AFULL_THR = 61,
  parameter logic [7:0]  PAD       = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 din,
  input  logic                       din_vld,
  input  logic                       din_last,
  output logic                       din_rdy,
  output logic [15:0]                dout,
  output logic                       dout_vld,
  output logic                       dout_last,
  output logic                       dout_odd,
  input  logic                       dout_rdy,
  output logic [$clog2(DEPTH):0]     usedw
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] THR = (AW+1)'(AFULL_THR);

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          ph;
  logic [7:0]    low_reg;
  logic          acc;
  logic          wr_en;
  logic          pop;
  logic [17:0]   wr_dat;
  logic [17:0]   rd_dat;

  // Only registered state feeds din_rdy, so upstream sees no combinational loop.
  assign din_rdy = (usedw < THR);
  assign acc     = din_vld && din_rdy;
  assign wr_en   = acc && (ph || din_last);
  assign pop     = (usedw != '0) && (!dout_vld || dout_rdy);
  assign rd_dat  = mem[rd_ptr];

  always_comb begin
    wr_dat = '0;
    if (ph) begin
      wr_dat = {1'b0, din_last, din, low_reg};
    end else begin
      wr_dat = {1'b1, 1'b1, PAD, din};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= 1'b0;
      low_reg <= 8'h00;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usedw   <= '0;
    end else begin
      if (acc) begin
        if (ph) begin
          ph <= 1'b0;
        end else if (!din_last) begin
          ph      <= 1'b1;
          low_reg <= din;
        end
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   usedw <= usedw + 1'b1;
        2'b01:   usedw <= usedw - 1'b1;
        default: usedw <= usedw;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= 16'h0000;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      dout_odd  <= 1'b0;
    end else begin
      if (pop) begin
        dout      <= rd_dat[15:0];
        dout_last <= rd_dat[16];
        dout_odd  <= rd_dat[17];
        dout_vld  <= 1'b1;
      end else if (dout_rdy) begin
        dout_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_pack_fifo.sv
// Directed and randomized checks of byte_pack_fifo packing, buffering, backpressure and reset.
module tb_byte_pack_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_vld = 1'b0;
  logic        din_last = 1'b0;
  logic        din_rdy;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_last;
  logic        dout_odd;
  logic        dout_rdy = 1'b0;
  logic [6:0]  usedw;

  int n_cmp  = 0;
  int n_fail = 0;

  byte_pack_fifo #(.DEPTH(64), .AFULL_THR(61), .PAD(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .din_last  (din_last),
    .din_rdy   (din_rdy),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_last (dout_last),
    .dout_odd  (dout_odd),
    .dout_rdy  (dout_rdy),
    .usedw     (usedw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int w;
    w = 0;
    din = b;
    din_last = l;
    din_vld = 1'b1;
    while (!din_rdy && w < 200) begin
      cyc();
      w++;
    end
    chk("send_rdy", din_rdy, 1);
    cyc();
    din_vld = 1'b0;
    din_last = 1'b0;
  endtask

  logic [17:0] q[$];
  logic [17:0] snap;
  logic [15:0] exp_w;
  logic        mph;
  logic [7:0]  mlow;
  logic        stall;
  logic        hold;
  logic        hi;
  logic        ho;
  logic        a;
  int          cnt;
  int          maxu;
  int          acc_bytes;

  initial begin
    // reset state
    #12;
    chk("rst_dout", dout, 16'h0000);
    chk("rst_vld", dout_vld, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_odd", dout_odd, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_din_rdy", din_rdy, 1);
    rst_n = 1'b1;
    cyc();

    // even pair
    dout_rdy = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    chk("t1_usedw_wr", usedw, 1);
    chk("t1_vld_early", dout_vld, 0);
    cyc();
    chk("t1_dout", dout, 16'h2211);
    chk("t1_vld", dout_vld, 1);
    chk("t1_last", dout_last, 1);
    chk("t1_odd", dout_odd, 0);
    chk("t1_usedw", usedw, 0);
    cyc();
    chk("t1_vld_drop", dout_vld, 0);

    // odd single byte then a fresh pair
    send(8'hA5, 1'b1);
    cyc();
    chk("t2_dout", dout, 16'h00A5);
    chk("t2_last", dout_last, 1);
    chk("t2_odd", dout_odd, 1);
    cyc();
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    cyc();
    chk("t2_pair", dout, 16'h0201);
    chk("t2_pair_odd", dout_odd, 0);
    chk("t2_pair_last", dout_last, 1);
    cyc();

    // fill to the almost-full threshold with the consumer stalled
    dout_rdy = 1'b0;
    cnt = 0;
    maxu = 0;
    for (int c = 0; c < 400 && cnt < 130; c++) begin
      din = cnt[7:0];
      din_vld = 1'b1;
      a = din_rdy;
      cyc();
      if (a) cnt++;
      if (int'(usedw) > maxu) maxu = int'(usedw);
    end
    din_vld = 1'b0;
    chk("t3_accepted", cnt, 124);
    chk("t3_usedw", usedw, 61);
    chk("t3_max_usedw", maxu, 61);
    chk("t3_din_rdy", din_rdy, 0);
    chk("t3_out_vld", dout_vld, 1);
    dout_rdy = 1'b1;
    for (int k = 0; k < 62; k++) begin
      int w;
      w = 0;
      while (!dout_vld && w < 50) begin
        cyc();
        w++;
      end
      exp_w = {8'(2*k+1), 8'(2*k)};
      chk("t3_word", dout, exp_w);
      cyc();
      if (k == 0) chk("t3_rdy_back", din_rdy, 1);
    end
    chk("t3_usedw_end", usedw, 0);
    chk("t3_vld_end", dout_vld, 0);

    // random traffic against a packing scoreboard
    mph = 1'b0;
    mlow = 8'h00;
    stall = 1'b0;
    hold = 1'b0;
    acc_bytes = 0;
    for (int c = 0; c < 60000 && acc_bytes < 10000; c++) begin
      if (stall) chk("t4_stable", {dout_odd, dout_last, dout}, snap);
      if (!hold) begin
        din = 8'($urandom);
        din_last = ($urandom_range(0, 3) == 0);
        din_vld = ($urandom_range(0, 9) < 7);
      end
      dout_rdy = ($urandom_range(0, 9) < 6);
      hi = din_vld && din_rdy;
      ho = dout_vld && dout_rdy;
      if (ho) begin
        chk("t4_q_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("t4_word", {dout_odd, dout_last, dout}, q[0]);
          void'(q.pop_front());
        end
      end
      stall = dout_vld && !dout_rdy;
      snap = {dout_odd, dout_last, dout};
      if (hi) begin
        acc_bytes++;
        if (mph) begin
          q.push_back({1'b0, din_last, din, mlow});
          mph = 1'b0;
        end else if (din_last) begin
          q.push_back({1'b1, 1'b1, 8'h00, din});
        end else begin
          mlow = din;
          mph = 1'b1;
        end
      end
      hold = din_vld && !hi;
      cyc();
    end
    chk("t4_bytes", acc_bytes, 10000);
    din_vld = 1'b0;
    dout_rdy = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (dout_vld) begin
        chk("t4_drain_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("t4_drain_word", {dout_odd, dout_last, dout}, q[0]);
          void'(q.pop_front());
        end
      end
      cyc();
    end
    chk("t4_q_left", q.size(), 0);
    chk("t4_usedw_end", usedw, 0);

    // asynchronous reset with a held half word and a partly full FIFO
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    dout_rdy = 1'b0;
    for (int i = 0; i < 12; i++) send(8'(8'h50 + i), 1'b0);
    send(8'h7E, 1'b0);
    cyc();
    chk("t5_usedw_pre", usedw, 5);
    chk("t5_vld_pre", dout_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_dout", dout, 16'h0000);
    chk("t5_vld", dout_vld, 0);
    chk("t5_last", dout_last, 0);
    chk("t5_odd", dout_odd, 0);
    chk("t5_usedw", usedw, 0);
    chk("t5_din_rdy", din_rdy, 1);
    cyc();
    rst_n = 1'b1;
    dout_rdy = 1'b1;
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    cyc();
    chk("t5_pair", dout, 16'h4433);
    chk("t5_pair_vld", dout_vld, 1);
    chk("t5_pair_last", dout_last, 1);
    chk("t5_pair_odd", dout_odd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
